// File: rtl/multi_audio_if.sv
// Frame handshake between the CPU I/O register block and multi_audio: packed PCM frame,
// level-change toggle strobe and FIFO status flags.
interface multi_audio_if #(
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned SAMPLE_BITS = 16
);
    logic [CHANNELS*SAMPLE_BITS-1:0] data;
    logic                            valid_toggle;
    logic                            full;
    logic                            empty;
    logic                            overrun;

    modport master (
        output data,
        output valid_toggle,
        input  full,
        input  empty,
        input  overrun
    );

    modport slave (
        input  data,
        input  valid_toggle,
        output full,
        output empty,
        output overrun
    );
endinterface

// File: rtl/multi_audio.sv
// Multi-channel delta-sigma audio output: toggle-handshake frame capture, frame FIFO,
// fractional-rate frame release, volume/mute conversion and first-order modulators.
module multi_audio #(
    parameter int unsigned CHANNELS           = 2,
    parameter int unsigned SAMPLE_BITS        = 16,
    parameter int unsigned FIFO_DEPTH_IN_BITS = 4,
    parameter int unsigned COUNTER_BITS       = 20,
    parameter bit          SIGNED_IN          = 1'b0
) (
    input  logic                           clk,
    input  logic                           reset,
    multi_audio_if.slave                   bus,
    input  logic signed [COUNTER_BITS-1:0] ext_factor_mul,
    input  logic signed [COUNTER_BITS-1:0] ext_factor_div,
    input  logic [3:0]                     ext_volume_shift,
    input  logic                           ext_mute,
    input  logic                           ext_underrun_hold,
    output logic [15:0]                    underrun_count,
    output logic [CHANNELS-1:0]            ext_audio
);

    localparam int unsigned FrameBits = CHANNELS * SAMPLE_BITS;
    localparam int unsigned Depth     = 2 ** FIFO_DEPTH_IN_BITS;
    localparam int unsigned CntW      = FIFO_DEPTH_IN_BITS + 1;

    localparam logic [CntW-1:0]        FullLevel = CntW'(Depth - 3);
    localparam logic [SAMPLE_BITS-1:0] Mid       = {1'b1, {(SAMPLE_BITS - 1){1'b0}}};
    localparam logic [FrameBits-1:0]   MidFrame  = {CHANNELS{Mid}};

    // Input capture
    logic                 toggle_q;
    logic                 toggle_prev_q;
    logic                 primed_q;
    logic [FrameBits-1:0] data_q;
    logic                 offered;
    logic                 wr_en;
    logic                 full;
    logic                 empty;
    logic                 overrun_q;

    always_ff @(posedge clk) begin
        toggle_q <= bus.valid_toggle;
        data_q   <= bus.data;
    end

    // The first edge after reset only primes toggle_prev, absorbing any level held in reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            toggle_prev_q <= 1'b0;
            primed_q      <= 1'b0;
        end else begin
            toggle_prev_q <= toggle_q;
            primed_q      <= 1'b1;
        end
    end

    assign offered = primed_q && (toggle_q != toggle_prev_q);
    assign wr_en   = offered && !full;

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (offered && full) begin
            overrun_q <= 1'b1;
        end
    end

    // Frame FIFO
    logic [FrameBits-1:0]          mem_q [Depth];
    logic [FIFO_DEPTH_IN_BITS-1:0] wr_ptr_q;
    logic [FIFO_DEPTH_IN_BITS-1:0] rd_ptr_q;
    logic [CntW-1:0]               count_q;
    logic                          pop;
    logic                          en_q;

    assign full  = (count_q >= FullLevel);
    assign empty = (count_q == '0);
    assign pop   = en_q && !empty;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({wr_en, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.full    = full;
    assign bus.empty   = empty;
    assign bus.overrun = overrun_q;

    // Fractional rate generator: accumulate mul, tick and subtract div on reaching div.
    logic signed [COUNTER_BITS:0]   mul_ext;
    logic signed [COUNTER_BITS:0]   div_ext;
    logic signed [COUNTER_BITS:0]   rate_sum;
    logic signed [COUNTER_BITS-1:0] rate_cnt_q;
    logic signed [COUNTER_BITS-1:0] rate_cnt_d;
    logic                           tick;

    always_comb begin
        mul_ext    = ext_factor_mul;
        div_ext    = ext_factor_div;
        rate_sum   = COUNTER_BITS'(rate_cnt_q) + mul_ext;
        rate_sum   = rate_cnt_q + mul_ext;
        tick       = (ext_factor_mul != '0) && (rate_sum >= div_ext);
        rate_cnt_d = tick ? COUNTER_BITS'(rate_sum - div_ext) : COUNTER_BITS'(rate_sum);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rate_cnt_q <= '0;
            en_q       <= 1'b0;
        end else begin
            rate_cnt_q <= rate_cnt_d;
            en_q       <= tick;
        end
    end

    // Read pipeline and underrun accounting
    logic [FrameBits-1:0] rd_data_q;
    logic [FrameBits-1:0] rd_offset;
    logic                 pop_q;
    logic                 starve_q;
    logic [FrameBits-1:0] sample_q;
    logic [15:0]          underrun_q;

    always_ff @(posedge clk) begin
        if (pop) begin
            rd_data_q <= mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pop_q      <= 1'b0;
            starve_q   <= 1'b0;
            underrun_q <= '0;
        end else begin
            pop_q    <= pop;
            starve_q <= en_q && empty;
            if (en_q && empty && (underrun_q != 16'hFFFF)) begin
                underrun_q <= underrun_q + 16'd1;
            end
        end
    end

    assign underrun_count = underrun_q;

    // Samples are kept as offset binary from here on.
    always_comb begin
        rd_offset = rd_data_q;
        if (SIGNED_IN) begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                rd_offset[k*SAMPLE_BITS+SAMPLE_BITS-1] = ~rd_data_q[k*SAMPLE_BITS+SAMPLE_BITS-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_q <= MidFrame;
        end else if (pop_q) begin
            sample_q <= rd_offset;
        end else if (starve_q && !ext_underrun_hold) begin
            sample_q <= MidFrame;
        end
    end

    // Conversion: attenuate around the midpoint so DC level is preserved.
    logic signed [SAMPLE_BITS:0] diff   [CHANNELS];
    logic signed [SAMPLE_BITS:0] scaled [CHANNELS];
    logic [SAMPLE_BITS-1:0]      conv_d [CHANNELS];
    logic [SAMPLE_BITS-1:0]      conv_q [CHANNELS];
    logic [SAMPLE_BITS:0]        acc_q  [CHANNELS];

    always_comb begin
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            diff[k]   = $signed({1'b0, sample_q[k*SAMPLE_BITS +: SAMPLE_BITS]})
                      - $signed({1'b0, Mid});
            scaled[k] = diff[k] >>> ext_volume_shift;
            conv_d[k] = ext_mute ? Mid : (scaled[k][SAMPLE_BITS-1:0] + Mid);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                conv_q[k] <= Mid;
                acc_q[k]  <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                conv_q[k] <= conv_d[k];
                acc_q[k]  <= {1'b0, acc_q[k][SAMPLE_BITS-1:0]} + {1'b0, conv_q[k]};
            end
        end
    end

    always_comb begin
        ext_audio = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            ext_audio[k] = acc_q[k][SAMPLE_BITS];
        end
    end

endmodule

// File: tb/tb_multi_audio.sv
// Scoreboard bench for multi_audio: an unsigned-input and a signed-input instance share
// the same stimulus; a monitor compares queued expectations against the outputs.
module tb_multi_audio;

    localparam int KEmpty = 0;
    localparam int KFull  = 1;
    localparam int KOver  = 2;
    localparam int KUnder = 3;
    localparam int KAudio = 4;
    localparam int KConv  = 5;
    localparam int KDens  = 6;

    typedef struct {
        string name;
        int    kind;
        int    dut;
        int    ch;
        int    exp;
        int    tol;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [31:0]        frame;
    logic               tog;
    logic signed [19:0] mul;
    logic signed [19:0] div;
    logic [3:0]         shift;
    logic               mute;
    logic               hold;
    logic [15:0]        uc_u;
    logic [15:0]        uc_s;
    logic [1:0]         audio_u;
    logic [1:0]         audio_s;

    multi_audio_if #(.CHANNELS(2), .SAMPLE_BITS(16)) bus_u ();
    multi_audio_if #(.CHANNELS(2), .SAMPLE_BITS(16)) bus_s ();

    assign bus_u.data         = frame;
    assign bus_u.valid_toggle = tog;
    assign bus_s.data         = frame;
    assign bus_s.valid_toggle = tog;

    multi_audio #(.SIGNED_IN(1'b0)) u_dut (
        .clk               (clk),
        .reset             (reset),
        .bus               (bus_u.slave),
        .ext_factor_mul    (mul),
        .ext_factor_div    (div),
        .ext_volume_shift  (shift),
        .ext_mute          (mute),
        .ext_underrun_hold (hold),
        .underrun_count    (uc_u),
        .ext_audio         (audio_u)
    );

    multi_audio #(.SIGNED_IN(1'b1)) u_dut_s (
        .clk               (clk),
        .reset             (reset),
        .bus               (bus_s.slave),
        .ext_factor_mul    (mul),
        .ext_factor_div    (div),
        .ext_volume_shift  (shift),
        .ext_mute          (mute),
        .ext_underrun_hold (hold),
        .underrun_count    (uc_s),
        .ext_audio         (audio_s)
    );

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic busy     = 1'b0;

    function automatic void want(string name, int kind, int dut, int ch, int exp, int tol = 0);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.dut  = dut;
        e.ch   = ch;
        e.exp  = exp;
        e.tol  = tol;
        sb.push_back(e);
    endfunction

    function automatic int actual(int kind, int dut, int ch);
        case (kind)
            KEmpty:  return dut == 0 ? int'(bus_u.empty) : int'(bus_s.empty);
            KFull:   return dut == 0 ? int'(bus_u.full) : int'(bus_s.full);
            KOver:   return dut == 0 ? int'(bus_u.overrun) : int'(bus_s.overrun);
            KUnder:  return dut == 0 ? int'(uc_u) : int'(uc_s);
            KAudio:  return dut == 0 ? int'(audio_u) : int'(audio_s);
            KConv: begin
                if (dut == 0) return ch == 0 ? int'(u_dut.conv_q[0]) : int'(u_dut.conv_q[1]);
                else          return ch == 0 ? int'(u_dut_s.conv_q[0]) : int'(u_dut_s.conv_q[1]);
            end
            default: return dut == 0 ? int'(audio_u[ch]) : int'(audio_s[ch]);
        endcase
    endfunction

    // Monitor: instant checks at the negedge; density checks count ones over 4096 cycles.
    initial begin
        exp_t e;
        int   act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                busy = 1'b1;
                e = sb.pop_front();
                if (e.kind == KDens) begin
                    act = 0;
                    for (int i = 0; i < 4096; i++) begin
                        act += actual(KDens, e.dut, e.ch);
                        if (i < 4095) @(negedge clk);
                    end
                end else begin
                    act = actual(e.kind, e.dut, e.ch);
                end
                n_checks++;
                if (act < e.exp - e.tol || act > e.exp + e.tol) begin
                    n_fail++;
                    $display("FAIL %s (dut%0d ch%0d): got %0d (0x%0h) expected %0d (0x%0h) tol %0d",
                             e.name, e.dut, e.ch, act, act, e.exp, e.exp, e.tol);
                end
            end
            busy = 1'b0;
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(logic [31:0] f);
        frame = f;
        tog   = ~tog;
        step(2);
    endtask

    task automatic sync();
        bit done = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (sb.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
            step(1);
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL sync: scoreboard still holds %0d entries, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        reset = 1'b1;
        tog   = 1'b1;
        frame = '0;
        mul   = '0;
        div   = 20'sd4;
        shift = '0;
        mute  = 1'b0;
        hold  = 1'b0;

        // Reset state with the toggle held high
        step(3);
        want("rst_empty", KEmpty, 0, 0, 1);
        want("rst_full", KFull, 0, 0, 0);
        want("rst_overrun", KOver, 0, 0, 0);
        want("rst_underrun", KUnder, 0, 0, 0);
        want("rst_audio", KAudio, 0, 0, 0);
        want("rst_conv", KConv, 0, 0, 'h8000);
        want("rst_conv_s", KConv, 1, 1, 'h8000);
        reset = 1'b0;
        step(10);
        want("prime_no_write", KEmpty, 0, 0, 1);
        want("prime_no_write_s", KEmpty, 1, 0, 1);
        want("prime_no_ticks", KUnder, 0, 0, 0);
        sync();

        // Starved ticks at mul/div = 1/2 over 20 cycles
        mul = 20'sd1;
        div = 20'sd2;
        step(20);
        mul = '0;
        step(3);
        want("underrun_20cyc", KUnder, 0, 0, 10);
        want("underrun_20cyc_s", KUnder, 1, 0, 10);
        want("underrun_mid", KConv, 0, 0, 'h8000);
        sync();

        // Fill to the write limit, then one dropped frame
        hold  = 1'b1;
        frame = 32'hC000_4000;
        tog   = ~tog;
        step(1);
        want("empty_before_t2", KEmpty, 0, 0, 1);
        step(1);
        want("empty_falls_t2", KEmpty, 0, 0, 0);
        for (int i = 0; i < 11; i++) send(32'hC000_4000);
        want("full_after_12", KFull, 0, 0, 0);
        send(32'hC000_4000);
        want("full_after_13", KFull, 0, 0, 1);
        want("no_overrun_13", KOver, 0, 0, 0);
        send(32'h1234_5678);
        want("overrun_14", KOver, 0, 0, 1);
        want("overrun_14_s", KOver, 1, 0, 1);
        want("full_14", KFull, 1, 0, 1);
        sync();

        // Drain: exactly 13 frames were stored
        mul = 20'sd1;
        div = 20'sd1;
        step(12);
        mul = '0;
        step(2);
        want("one_left", KEmpty, 0, 0, 0);
        want("one_left_full", KFull, 0, 0, 0);
        mul = 20'sd1;
        step(1);
        mul = '0;
        step(3);
        want("drained", KEmpty, 0, 0, 1);
        want("no_starve_drain", KUnder, 0, 0, 10);
        want("overrun_sticky", KOver, 0, 0, 1);
        sync();

        // Ones density while starving with hold=1 (last frame repeats)
        mul = 20'sd1;
        div = 20'sd4;
        step(8);
        want("dens_ch1_075", KDens, 0, 1, 3072, 1);
        want("dens_ch0_025", KDens, 0, 0, 1024, 1);
        want("dens_s_ch0_075", KDens, 1, 0, 3072, 1);
        sync();
        hold = 1'b0;
        step(8);
        want("dens_hold0_mid", KDens, 0, 1, 2048, 1);
        want("conv_hold0_mid_s", KConv, 1, 0, 'h8000);
        sync();
        mul = '0;
        step(2);

        // Signed input and attenuation
        hold = 1'b1;
        send(32'h7FFF_0000);
        mul = 20'sd1;
        div = 20'sd1;
        step(1);
        mul = '0;
        step(5);
        want("s_zero_unity", KConv, 1, 0, 'h8000);
        want("s_7fff_unity", KConv, 1, 1, 'hFFFF);
        want("u_7fff_unity", KConv, 0, 1, 'h7FFF);
        shift = 4'd1;
        step(1);
        want("s_7fff_shift1", KConv, 1, 1, 'hBFFF);
        want("s_zero_shift1", KConv, 1, 0, 'h8000);
        want("u_zero_shift1", KConv, 0, 0, 'h4000);
        want("u_7fff_shift1", KConv, 0, 1, 'h7FFF);
        sync();

        // Mute takes effect on the next clock and releases cleanly
        mute = 1'b1;
        step(1);
        want("mute_s", KConv, 1, 1, 'h8000);
        want("mute_u", KConv, 0, 0, 'h8000);
        mute = 1'b0;
        step(1);
        want("unmute_s", KConv, 1, 1, 'hBFFF);
        want("unmute_u", KConv, 0, 0, 'h4000);
        sync();

        // Reset mid-operation with a toggle in flight
        send(32'h1111_2222);
        send(32'h3333_4444);
        want("pre_reset_fill", KEmpty, 0, 0, 0);
        frame = 32'h5555_6666;
        tog   = ~tog;
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        want("midrst_empty", KEmpty, 0, 0, 1);
        want("midrst_overrun", KOver, 0, 0, 0);
        want("midrst_underrun", KUnder, 0, 0, 0);
        want("midrst_conv", KConv, 0, 0, 'h8000);
        step(6);
        want("midrst_no_inflight", KEmpty, 0, 0, 1);
        want("midrst_no_inflight_s", KEmpty, 1, 0, 1);
        sync();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_audio.md
# multi_audio

Parametrised successor to the two-channel delta-sigma audio output: accepts packed PCM frames for `CHANNELS` channels through a toggle handshake and buffers them in an internal FIFO. Frames are released at a fractional rate (`frac_clk`), and each channel is driven by a first-order delta-sigma modulator to produce a 1-bit output. Adds signed input, volume attenuation, mute, selectable underrun policy and status counters. Sits between the CPU I/O register block and the board audio pins.

## Interface
- `CHANNELS`, 2, number of audio channels (1..8)
- `SAMPLE_BITS`, 16, PCM sample width per channel
- `FIFO_DEPTH_IN_BITS`, 4, FIFO depth = 2^N frames
- `COUNTER_BITS`, 20, width of rate factors; must exceed factor bit width + 1
- `SIGNED_IN`, 0, 1: input samples two's complement; 0: offset binary (unsigned)
- `clk`  in  1  system clock
- `reset`  in  1  reset; one clock, synchronous, active-high
- `data`  in  CHANNELS*SAMPLE_BITS  frame; channel k at `[k*SAMPLE_BITS +: SAMPLE_BITS]`
- `valid_toggle`  in  1  each level change offers one frame
- `ext_factor_mul`  in  signed COUNTER_BITS  rate numerator (e.g. 48 kHz*2/16 MHz → 3)
- `ext_factor_div`  in  signed COUNTER_BITS  rate denominator (→ 500)
- `ext_volume_shift`  in  4  attenuation, 6.02 dB per step (0 = unity)
- `ext_mute`  in  1  force midscale on all channels
- `ext_underrun_hold`  in  1  1: repeat last frame on underrun; 0: output midscale
- `full`  out  1  FIFO at write limit
- `empty`  out  1  FIFO holds no frames
- `overrun`  out  1  sticky: a frame was offered while full
- `underrun_count`  out  16  saturating count of starved rate ticks
- `ext_audio`  out  CHANNELS  1-bit delta-sigma outputs

## Operation
- Input capture: `valid_toggle` and `data` are registered once; `toggle_prev` holds the previous registered toggle. Write when registered toggle ≠ `toggle_prev` and `full`=0. If `full`=1, the frame is dropped and `overrun` is set.
- Priming: the first registered toggle after reset is loaded into `toggle_prev` without a write, so `valid_toggle`=1 during reset never writes a spurious frame.
- FIFO: 2^D entries. `full` = count ≥ 2^D−3, leaving margin for the capture pipeline. `empty` = count==0. Simultaneous write and pop leaves count unchanged; pointers wrap modulo 2^D.
- Rate: `frac_clk` emits a one-cycle `en` at average rate mul/div per clock. `ext_factor_mul`=0 means no ticks.
- On `en`: if `empty`=0, pop one frame. If `empty`=1, which is evaluated on the pre-edge state so a same-cycle write does not count, do not pop, increment `underrun_count` (saturates at 0xFFFF), and load the sample register per `ext_underrun_hold`.
- Conversion: if `SIGNED_IN`=1, invert the MSB to get offset binary. Let mid = 2^(SAMPLE_BITS−1). Output y = ((u − mid) >>> shift) + mid, using signed arithmetic at SAMPLE_BITS+1 bits, so attenuation preserves the DC midpoint. `ext_mute`=1 gives y = mid.
- Modulator per channel: acc[SAMPLE_BITS:0] <= acc[SAMPLE_BITS−1:0] + y, and `ext_audio[k]` = acc[SAMPLE_BITS]. Ones density = y/2^SAMPLE_BITS.

## Timing
- Reset values: `full`=0, `empty`=1, `overrun`=0, `underrun_count`=0, `ext_audio`=0, accumulators 0, sample and conversion registers = mid, FIFO pointers 0.
- Reset mid-operation flushes the FIFO and discards any in-flight toggle. It does not wait for a frame boundary.
- Toggle edge on pin at cycle t: FIFO write at edge t+2, so `empty` falls at t+2 (`full` likewise reflects it).
- `en` at cycle t: FIFO read data valid t+1, sample register updated t+2, conversion register t+3, accumulator/`ext_audio` t+4.
- `ext_volume_shift`/`ext_mute` changes take effect at the conversion register on the next clock, independent of `en`.
- Max sustained input: one frame per 2 clocks (toggle must hold ≥2 cycles per level).

## Test plan
- Reset with `valid_toggle`=1, release, hold 10 cycles → no write; `empty`=1, `underrun_count` counts ticks only.
- SAMPLE_BITS=16, mul=1 div=4, write frame {0xC000,0x4000} repeatedly → over 4096 cycles after fill, ch1 ones density 0.75±1/4096, ch0 0.25.
- SIGNED_IN=1, sample 0x0000, shift=0 → density 0.5. Sample 0x7FFF with shift=1 → y=0xBFFF.
- Write 14 frames with mul=0 → `full`=1 after 13th. 14th drops and `overrun`=1; count stays 13.
- Empty FIFO, mul=1 div=2, 20 cycles → `underrun_count`=10. With hold=0, y=0x8000. With hold=1, last frame repeats.
- Mute toggled mid-stream → within 1 cycle conversion=0x8000; unmute restores attenuated stream with no pop lost.
